// File: rtl/forth_pkg.sv
// rtl/forth_pkg.sv - shared opcode, select, error-code and state definitions for the stack controller
package forth_pkg;

  // Operation codes; 6 and 7 are illegal.
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;
  localparam logic [2:0] OP_OVER = 3'd5;

  // Per-register source select: literal, shallower neighbour P(i-1), deeper neighbour P(i+1).
  localparam logic [1:0] SEL_LIT  = 2'd0;
  localparam logic [1:0] SEL_SHAL = 2'd1;
  localparam logic [1:0] SEL_DEEP = 2'd2;

  // Error codes.
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // Occupancy after a legal op completes.
  function automatic logic [2:0] depth_after(input logic [2:0] op, input logic [2:0] d);
    logic [2:0] r;
    case (op)
      OP_PUSH, OP_DUP, OP_OVER: r = d + 3'd1;
      OP_POP:                   r = d - 3'd1;
      default:                  r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stack_mask_dec.sv
// rtl/stack_mask_dec.sv - combinational load-mask / source-select / error decoder
//
// Ports:
//   op_code  in   3          requested operation
//   depth    in   3          current occupancy
//   p_f      out  DEPTH      load enable per stack register
//   p_sel    out  2*DEPTH    source select per register ([2i+1:2i] for Pi)
//   err_code out  2          nonzero when the op cannot execute at this depth
module stack_mask_dec
  import forth_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [2:0]         op_code,
  input  logic [2:0]         depth,
  output logic [DEPTH-1:0]   p_f,
  output logic [2*DEPTH-1:0] p_sel,
  output logic [1:0]         err_code
);

  int d;

  always_comb begin
    p_f      = '0;
    p_sel    = '0;
    err_code = ERR_NONE;
    d        = {29'd0, depth};

    case (op_code)
      OP_NOP: begin
      end

      OP_PUSH: begin
        if (d >= DEPTH) begin
          err_code = ERR_OVF;
        end else begin
          // New literal lands in P0, P0..P(d-1) shift one deeper.
          for (int i = 0; i < DEPTH; i++) begin
            if (i <= d) begin
              p_f[i]         = 1'b1;
              p_sel[2*i +: 2] = (i == 0) ? SEL_LIT : SEL_SHAL;
            end
          end
        end
      end

      OP_POP: begin
        if (d < 1) begin
          err_code = ERR_UNF;
        end else begin
          // Everything below the top moves up one; the vacated bottom slot is left stale.
          for (int i = 0; i < DEPTH; i++) begin
            if (i + 2 <= d) begin
              p_f[i]         = 1'b1;
              p_sel[2*i +: 2] = SEL_DEEP;
            end
          end
        end
      end

      OP_DUP: begin
        if (d < 1) begin
          err_code = ERR_UNF;
        end else if (d >= DEPTH) begin
          err_code = ERR_OVF;
        end else begin
          // P0 keeps its value; the copy is P1 taking P0.
          for (int i = 1; i < DEPTH; i++) begin
            if (i <= d) begin
              p_f[i]         = 1'b1;
              p_sel[2*i +: 2] = SEL_SHAL;
            end
          end
        end
      end

      OP_SWAP: begin
        if (d < 2) begin
          err_code = ERR_UNF;
        end else begin
          p_f[1:0]   = 2'b11;
          p_sel[1:0] = SEL_DEEP;
          p_sel[3:2] = SEL_SHAL;
        end
      end

      OP_OVER: begin
        if (d < 2) begin
          err_code = ERR_UNF;
        end else if (d >= DEPTH) begin
          err_code = ERR_OVF;
        end else begin
          // Old P1 becomes the top, everything else shifts deeper.
          for (int i = 0; i < DEPTH; i++) begin
            if (i <= d) begin
              p_f[i]         = 1'b1;
              p_sel[2*i +: 2] = (i == 0) ? SEL_DEEP : SEL_SHAL;
            end
          end
        end
      end

      default: begin
        err_code = ERR_ILL;
      end
    endcase
  end

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - register-stack controller FSM with depth tracking and sticky errors
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   op_valid   operation request; accepted when op_ready is also high
//   op_code    operation (NOP/PUSH/POP/DUP/SWAP/OVER)
//   op_data    literal for PUSH
//   op_ready   high only while idle
//   p_f        per-register load enable, nonzero only during the execute cycle
//   p_sel      per-register source select, 2 bits per register
//   lit_out    captured literal, held until the next accepted op
//   depth      occupied entries
//   err        sticky error flag, err_code gives the cause
//   err_clr    leaves the error state
module stack_ctrl
  import forth_pkg::*;
#(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [2:0]         op_code,
  input  logic [W-1:0]       op_data,
  output logic               op_ready,
  output logic [DEPTH-1:0]   p_f,
  output logic [2*DEPTH-1:0] p_sel,
  output logic [W-1:0]       lit_out,
  output logic [2:0]         depth,
  output logic               err,
  output logic [1:0]         err_code,
  input  logic               err_clr
);

  state_t             state, state_nxt;
  logic [DEPTH-1:0]   dec_p_f;
  logic [2*DEPTH-1:0] dec_p_sel;
  logic [1:0]         dec_err;

  // Depth the stack will have once the op in EXEC completes; committed on the edge leaving EXEC.
  logic [2:0]         depth_pend, depth_pend_nxt;

  logic               op_ready_nxt;
  logic [DEPTH-1:0]   p_f_nxt;
  logic [2*DEPTH-1:0] p_sel_nxt;
  logic [W-1:0]       lit_nxt;
  logic [2:0]         depth_nxt;
  logic               err_nxt;
  logic [1:0]         err_code_nxt;

  stack_mask_dec #(.DEPTH(DEPTH)) u_dec (
    .op_code  (op_code),
    .depth    (depth),
    .p_f      (dec_p_f),
    .p_sel    (dec_p_sel),
    .err_code (dec_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_ready   <= 1'b1;
      p_f        <= '0;
      p_sel      <= '0;
      lit_out    <= '0;
      depth      <= '0;
      depth_pend <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_nxt;
      op_ready   <= op_ready_nxt;
      p_f        <= p_f_nxt;
      p_sel      <= p_sel_nxt;
      lit_out    <= lit_nxt;
      depth      <= depth_nxt;
      depth_pend <= depth_pend_nxt;
      err        <= err_nxt;
      err_code   <= err_code_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    p_f_nxt        = '0;
    p_sel_nxt      = '0;
    lit_nxt        = lit_out;
    depth_nxt      = depth;
    depth_pend_nxt = depth_pend;
    err_nxt        = err;
    err_code_nxt   = err_code;

    case (state)
      ST_IDLE: begin
        if (op_valid) begin
          if (dec_err != ERR_NONE) begin
            state_nxt    = ST_ERR;
            err_nxt      = 1'b1;
            err_code_nxt = dec_err;
          end else begin
            state_nxt      = ST_EXEC;
            p_f_nxt        = dec_p_f;
            p_sel_nxt      = dec_p_sel;
            lit_nxt        = op_data;
            depth_pend_nxt = depth_after(op_code, depth);
          end
        end
      end

      ST_EXEC: begin
        state_nxt = ST_IDLE;
        depth_nxt = depth_pend;
      end

      ST_ERR: begin
        if (err_clr) begin
          state_nxt    = ST_IDLE;
          err_nxt      = 1'b0;
          err_code_nxt = ERR_NONE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    op_ready_nxt = (state_nxt == ST_IDLE);
  end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter W, default 3, meaning data width of each stack register.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of stack registers P0 (top) to P3.
REQ-003 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port op_valid  in  1  operation request.
REQ-006 SHALL have port op_code  in  3  0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 OVER, 6-7 illegal.
REQ-007 SHALL have port op_data  in  W  literal for PUSH.
REQ-008 SHALL have port op_ready  out  1  high only in IDLE; an op is accepted on an edge where op_valid & op_ready.
REQ-009 SHALL have port p_f  out  DEPTH  per-register load flag, bit i drives Pi load enable.
REQ-010 SHALL have port p_sel  out  2*DEPTH  per-register source select, bits [2i+1:2i] for Pi: 0 LIT, 1 SHAL (from P(i-1)), 2 DEEP (from P(i+1)); 3 never driven.
REQ-011 SHALL have port lit_out  out  W  captured op_data, stable through EXEC.
REQ-012 SHALL have port depth  out  3  occupied entries, 0..DEPTH.
REQ-013 SHALL have port err  out  1  sticky error flag.
REQ-014 SHALL have port err_code  out  2  01 overflow, 10 underflow, 11 illegal opcode.
REQ-015 SHALL have port err_clr  in  1  clears error state.

Function
REQ-016 FSM SHALL have states IDLE, EXEC, ERR; all outputs registered.
REQ-017 IDLE: on acceptance of a legal op, go to EXEC; lit_out <= op_data; p_f/p_sel for that op loaded for the EXEC cycle.
REQ-018 EXEC lasts exactly one cycle, then IDLE; p_f nonzero only in EXEC; stack registers load on the edge ending EXEC; depth updates on that same edge.
REQ-019 Throughput SHALL be one op per 2 cycles; op_ready low in EXEC and ERR.
REQ-020 With current depth d: PUSH (d<4): P0 LIT, P1..Pd SHAL, p_f bits 0..d set, depth d+1.
REQ-021 POP (d>=1): P0..P(d-2) DEEP, those bits set (none if d=1), depth d-1.
REQ-022 DUP (1<=d<4): P1..Pd SHAL, bit 0 clear, depth d+1.
REQ-023 SWAP (d>=2): P0 DEEP, P1 SHAL, p_f=0011, depth unchanged.
REQ-024 OVER (2<=d<4): P0 DEEP, P1..Pd SHAL, bits 0..d set, depth d+1.
REQ-025 NOP SHALL pass through EXEC with p_f=0, depth unchanged.
REQ-026 p_sel fields of registers with p_f bit clear SHALL be 0.
REQ-027 Overflow (PUSH/DUP/OVER at d=4), underflow (POP/DUP at d=0, SWAP/OVER at d<2), illegal opcode: go IDLE->ERR directly, no EXEC, p_f=0, depth unchanged, err=1, err_code set.
REQ-028 ERR holds until err_clr=1, then IDLE next cycle with err=0, err_code=0; op_valid during ERR ignored, including the err_clr cycle.
REQ-029 err_clr outside ERR SHALL have no effect.

Reset
REQ-030 rst SHALL asynchronously force IDLE, op_ready=1, p_f=0, p_sel=0, lit_out=0, depth=0, err=0, err_code=0, including mid-EXEC (pending load abandoned, depth not updated).

Structure
REQ-031 Opcode, select and error-code constants SHALL live in shared package forth_pkg.
REQ-032 Mask/select generation SHALL be one combinational sub-module stack_mask_dec (inputs op_code, depth; outputs p_f, p_sel, err_code); FSM and depth counter stay in stack_ctrl.

Verification
REQ-033 After reset, PUSH 5, PUSH 3 -> EXEC cycles show p_f=0001 sel P0=0 lit_out=5, then p_f=0011 sel P0=0 P1=1 lit_out=3; depth=2.
REQ-034 Depth 2, SWAP -> p_f=0011, P0 sel 2, P1 sel 1, depth stays 2; OVER -> p_f=0111, depth 3.
REQ-035 Four PUSHes then PUSH -> err=1, err_code=01, no EXEC, depth 4; err_clr -> IDLE next cycle, err=0.
REQ-036 Depth 0, POP -> err_code=10; after err_clr, op_code=7 -> err_code=11.
REQ-037 Depth 1, POP -> EXEC with p_f=0000, depth 0; op_valid held continuously -> accepted every 2nd cycle only.
REQ-038 rst pulsed during EXEC of PUSH at depth 2 -> p_f=0 immediately, depth=0, op_ready=1 after release.
